ga_gen_scheduler: RTL

//  Top-level sequencer for the genetic-algorithm run. Drives the population

---
 rtl/ga_pkg.sv | 31 +++
 rtl/seed_lfsr.sv | 32 +++
 rtl/ga_gen_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ga_pkg.sv
// Shared types and defaults for the genetic-algorithm datapath blocks.
// Holds scheduler state encoding, widths, and the seed LFSR step function.
package ga_pkg;

    localparam int          GEN_W_DEF     = 16;
    localparam int          FIT_W_DEF     = 16;
    localparam logic [31:0] LFSR_TAPS_DEF = 32'h8020_0003;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_INIT_GO = 4'd1,
        ST_INIT_WT = 4'd2,
        ST_EVAL_GO = 4'd3,
        ST_EVAL_WT = 4'd4,
        ST_SEL_GO  = 4'd5,
        ST_SEL_WT  = 4'd6,
        ST_BRD_GO  = 4'd7,
        ST_BRD_WT  = 4'd8,
        ST_FINISH  = 4'd9,
        ST_FAULT   = 4'd10
    } state_t;

    // Right-shifting Galois step: feedback taps XORed in when a 1 falls out.
    function automatic logic [31:0] lfsr_step(
        input logic [31:0] s,
        input logic [31:0] taps
    );
        return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    endfunction

endpackage

// File: rtl/seed_lfsr.sv
// 32-bit Galois LFSR holding the run seed; loadable and single-stepped.
// Ports: clk, rst (sync high), load/load_val, step, out (value after next step).
module seed_lfsr
    import ga_pkg::*;
#(
    parameter logic [31:0] TAPS = LFSR_TAPS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        step,
    output logic [31:0] out
);

    logic [31:0] state_q;

    // Exposing the post-step value lets the consumer capture the new
    // seed on the same edge the register advances.
    assign out = lfsr_step(state_q, TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else if (load) begin
            state_q <= load_val;
        end else if (step) begin
            state_q <= out;
        end
    end

endmodule

// File: rtl/ga_gen_scheduler.sv
// Top-level GA run sequencer: init -> eval -> (sel -> brd -> eval)* -> done.
// Ports: run control (start/prg_seed/max_gen/fit_target), stage start/done pairs,
//  best_fit from evaluator, stage_seed, generation, busy, done, error.
module ga_gen_scheduler
    import ga_pkg::*;
#(
    parameter int          GEN_W     = GEN_W_DEF,
    parameter int          FIT_W     = FIT_W_DEF,
    parameter int          TIMEOUT   = 1000000,
    parameter logic [31:0] LFSR_TAPS = LFSR_TAPS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      prg_seed,
    input  logic [GEN_W-1:0] max_gen,
    input  logic [FIT_W-1:0] fit_target,
    input  logic [FIT_W-1:0] best_fit,
    output logic [31:0]      stage_seed,
    output logic             init_start,
    input  logic             init_done,
    output logic             eval_start,
    input  logic             eval_done,
    output logic             sel_start,
    input  logic             sel_done,
    output logic             brd_start,
    input  logic             brd_done,
    output logic [GEN_W-1:0] generation,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT);

    state_t             state_q, state_d;
    logic [3:0]         pulse_q, pulse_d;
    logic [WD_W-1:0]    wd_q, wd_d, wd_inc;
    logic [GEN_W-1:0]   max_gen_q;
    logic [FIT_W-1:0]   fit_tgt_q;
    logic [31:0]        seed_init, lfsr_nxt;
    logic [GEN_W:0]     gen_nxt;
    logic               accept, go, gen_inc, to_fault;
    logic               armed, wd_hit, fit_hit, last_gen;

    assign init_start = pulse_q[0];
    assign eval_start = pulse_q[1];
    assign sel_start  = pulse_q[2];
    assign brd_start  = pulse_q[3];
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FINISH);

    // A done is only trusted once the start pulse has been seen by the
    // stage, so levels left over from the previous handshake are ignored.
    assign armed    = ~|pulse_q;
    assign wd_inc   = wd_q + WD_W'(1);
    assign wd_hit   = (wd_inc >= WD_LIM);
    assign fit_hit  = (best_fit >= fit_tgt_q);
    // Checked before the increment, so generation can never wrap.
    assign gen_nxt  = {1'b0, generation} + (GEN_W + 1)'(1);
    assign last_gen = (gen_nxt >= {1'b0, max_gen_q});

    assign seed_init = (prg_seed == 32'd0) ? 32'd1 : prg_seed;

    seed_lfsr #(
        .TAPS     (LFSR_TAPS)
    ) u_seed_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (seed_init),
        .step     (go),
        .out      (lfsr_nxt)
    );

    always_comb begin
        state_d  = state_q;
        pulse_d  = '0;
        wd_d     = wd_q;
        accept   = 1'b0;
        go       = 1'b0;
        gen_inc  = 1'b0;
        to_fault = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_FAULT: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_INIT_GO;
                end
            end
            ST_INIT_GO: begin
                go         = 1'b1;
                pulse_d[0] = 1'b1;
                wd_d       = '0;
                state_d    = ST_INIT_WT;
            end
            ST_EVAL_GO: begin
                go         = 1'b1;
                pulse_d[1] = 1'b1;
                wd_d       = '0;
                state_d    = ST_EVAL_WT;
            end
            ST_SEL_GO: begin
                go         = 1'b1;
                pulse_d[2] = 1'b1;
                wd_d       = '0;
                state_d    = ST_SEL_WT;
            end
            ST_BRD_GO: begin
                go         = 1'b1;
                pulse_d[3] = 1'b1;
                wd_d       = '0;
                state_d    = ST_BRD_WT;
            end
            ST_INIT_WT: begin
                wd_d = wd_inc;
                if (armed && init_done) begin
                    state_d = ST_EVAL_GO;
                end else if (wd_hit) begin
                    to_fault = 1'b1;
                end
            end
            ST_EVAL_WT: begin
                wd_d = wd_inc;
                if (armed && eval_done) begin
                    state_d = (fit_hit || last_gen) ? ST_FINISH : ST_SEL_GO;
                end else if (wd_hit) begin
                    to_fault = 1'b1;
                end
            end
            ST_SEL_WT: begin
                wd_d = wd_inc;
                if (armed && sel_done) begin
                    state_d = ST_BRD_GO;
                end else if (wd_hit) begin
                    to_fault = 1'b1;
                end
            end
            ST_BRD_WT: begin
                wd_d = wd_inc;
                if (armed && brd_done) begin
                    gen_inc = 1'b1;
                    state_d = ST_EVAL_GO;
                end else if (wd_hit) begin
                    to_fault = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (to_fault) begin
            state_d = ST_FAULT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pulse_q    <= '0;
            wd_q       <= '0;
            max_gen_q  <= '0;
            fit_tgt_q  <= '0;
            generation <= '0;
            error      <= 1'b0;
            stage_seed <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            wd_q    <= wd_d;
            if (accept) begin
                max_gen_q  <= (max_gen == '0) ? GEN_W'(1) : max_gen;
                fit_tgt_q  <= fit_target;
                generation <= '0;
                error      <= 1'b0;
            end else if (gen_inc) begin
                generation <= generation + GEN_W'(1);
            end
            if (to_fault) begin
                error <= 1'b1;
            end
            if (go) begin
                stage_seed <= lfsr_nxt;
            end
        end
    end

endmodule
